// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared types and defaults for the stream cipher feeder
package stream_cipher_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} feeder_state_e;
    localparam int CIPHER_LAT_DEF = 2;
endpackage

// File: rtl/feeder_fifo.sv
// feeder_fifo: synchronous byte FIFO with occupancy count, DEPTH a power of two
module feeder_fifo import stream_cipher_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  byte_t                    din,
    output byte_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    byte_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign full  = count == ($clog2(DEPTH)+1)'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + ($clog2(DEPTH)+1)'(wr) - ($clog2(DEPTH)+1)'(rd);
        end
    end
endmodule

// File: rtl/stream_cipher_feeder.sv
// stream_cipher_feeder: key latch, byte FIFO and issue/flush FSM; STREAM_CIPHER_FEEDER_LEN_EN adds msg_len counter
module stream_cipher_feeder import stream_cipher_pkg::*; #(
    parameter int DEPTH      = 8,
    parameter int CIPHER_LAT = CIPHER_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [7:0]  key_in,
    input  logic        host_valid,
    input  logic [7:0]  host_data,
    input  logic        host_last,
    output logic        host_ready,
    input  logic        sink_stall,
    output logic        din_valid,
    output logic [7:0]  txt_in_char,
    output logic [7:0]  simmetric_key,
    output logic        msg_done,
    output logic        key_err,
    output logic [15:0] msg_len
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $clog2(CIPHER_LAT) + 1;
    feeder_state_e state;
    byte_t key_q, fifo_dout;
    logic last_seen, full, empty, push, pop;
    logic [CW-1:0] count;
    logic [FW-1:0] flush_cnt;
    assign host_ready    = state == RUN && !full && !last_seen;
    assign push          = host_valid && host_ready;
    assign pop           = state == RUN && !empty && !sink_stall;
    assign simmetric_key = key_q;
    feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(host_data),
        .dout(fifo_dout), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_q       <= '0;
            last_seen   <= 1'b0;
            din_valid   <= 1'b0;
            txt_in_char <= '0;
            msg_done    <= 1'b0;
            key_err     <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            msg_done  <= 1'b0;
            din_valid <= pop;
            if (pop) txt_in_char <= fifo_dout;
            if (key_load && state != IDLE) key_err <= 1'b1;
            case (state)
                IDLE: if (key_load) begin
                    key_q     <= key_in;
                    last_seen <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (push && host_last) last_seen <= 1'b1;
                    // the final pop empties the FIFO; no push can race it once last_seen is set
                    if (pop && last_seen && count == CW'(1)) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FW'(CIPHER_LAT - 1)) begin
                        msg_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef STREAM_CIPHER_FEEDER_LEN_EN
    logic [15:0] len_q;
    always_ff @(posedge clk) begin
        if (!rst_n) len_q <= '0;
        else if (state == IDLE && key_load) len_q <= '0;
        else if (pop && len_q != 16'hFFFF) len_q <= len_q + 1'b1;
    end
    assign msg_len = len_q;
`else
    assign msg_len = '0;
`endif
endmodule
